// File: rtl/word_shift_pkg.sv
// Shared definitions for the word_shift sequencer slice.
// FSM state encoding and the width helpers derived from the field length.

package word_shift_pkg;

    // Sequencer state: IDLE holds no word, RUN has copies pending.
    typedef enum logic {
        WSS_IDLE = 1'b0,
        WSS_RUN  = 1'b1
    } wss_state_e;

    // Index of the highest set bit; 0 maps to 0 so widths never collapse.
    function automatic int msb(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if (((v >> i) & 1) != 0) begin
                r = i;
            end
        end
        return r;
    endfunction

    // Width of a character offset inside the field (0..n-1).
    function automatic int pos_w(input int n);
        return msb(n - 1) + 1;
    endfunction

    // Width of a word length (0..n).
    function automatic int len_w(input int n);
        return msb(n) + 1;
    endfunction

endpackage

// File: rtl/word_shift.sv
// Places a left-aligned word at a character offset inside the field.
// Characters shift toward the LSBs; vacated characters are zero.

module word_shift
    import word_shift_pkg::*;
#(
    parameter int CHAR_BITS    = 7,
    parameter int WORD_MAX_LEN = 8,
    localparam int POS_W       = pos_w(WORD_MAX_LEN),
    localparam int WORD_W      = WORD_MAX_LEN * CHAR_BITS
) (
    input  logic [WORD_W-1:0] word_i,
    input  logic [POS_W-1:0]  pos_i,
    output logic [WORD_W-1:0] word_o
);

    // Character-granular barrel shift: char k of the input lands at char k+pos.
    always_comb begin
        word_o = '0;
        for (int p = 0; p < WORD_MAX_LEN; p++) begin
            if (pos_i == POS_W'(p)) begin
                word_o = word_i >> (p * CHAR_BITS);
            end
        end
    end

endmodule

// File: rtl/word_shift_seq.sv
// Emits one shifted copy of each input word per legal character offset.
// Define WORD_SHIFT_SEQ_REVERSE_EN to emit offsets in descending order.

module word_shift_seq
    import word_shift_pkg::*;
#(
    parameter int CHAR_BITS    = 7,
    parameter int WORD_MAX_LEN = 8,
    localparam int POS_W       = pos_w(WORD_MAX_LEN),
    localparam int LEN_W       = len_w(WORD_MAX_LEN),
    localparam int WORD_W      = WORD_MAX_LEN * CHAR_BITS
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WORD_W-1:0] in_word,
    input  logic [LEN_W-1:0]  in_len,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [POS_W-1:0]  out_pos,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [LEN_W-1:0] FIELD_LEN = LEN_W'(WORD_MAX_LEN);

    wss_state_e        state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [POS_W-1:0]  maxp_q, maxp_d;

    logic [LEN_W-1:0]  eff_len;
    logic [LEN_W-1:0]  max_pos_full;
    logic [POS_W-1:0]  in_max_pos;
    logic [POS_W-1:0]  in_first_pos;
    logic [POS_W-1:0]  final_pos;
    logic [POS_W-1:0]  next_pos;
    logic              run;
    logic              at_final;
    logic              out_hs;
    logic              in_hs;
    logic [WORD_W-1:0] shifted;

    // Clamp the incoming length and derive the highest legal offset.
    always_comb begin
        eff_len      = (in_len > FIELD_LEN) ? FIELD_LEN : in_len;
        max_pos_full = FIELD_LEN - eff_len;
        in_max_pos   = POS_W'(max_pos_full);
    end

`ifdef WORD_SHIFT_SEQ_REVERSE_EN
    // Descending walk: start at the highest offset, finish at offset 0.
    always_comb begin
        in_first_pos = in_max_pos;
        final_pos    = '0;
        next_pos     = pos_q - POS_W'(1);
    end
`else
    // Ascending walk: start at offset 0, finish at the stored highest offset.
    always_comb begin
        in_first_pos = '0;
        final_pos    = maxp_q;
        next_pos     = pos_q + POS_W'(1);
    end
`endif

    // Handshake qualifiers shared by the next-state logic and the outputs.
    always_comb begin
        run      = (state_q == WSS_RUN);
        at_final = (pos_q == final_pos);
        out_hs   = run & out_ready;
        in_ready = ~run | (out_ready & at_final);
        in_hs    = in_valid & in_ready;
    end

    // Next-state: advance on each output handshake, reload on each input one.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        pos_d   = pos_q;
        maxp_d  = maxp_q;
        if (out_hs) begin
            if (at_final) begin
                state_d = WSS_IDLE;
            end else begin
                pos_d = next_pos;
            end
        end
        if (in_hs) begin
            if (in_len == '0) begin
                state_d = WSS_IDLE;
            end else begin
                word_d  = in_word;
                maxp_d  = in_max_pos;
                pos_d   = in_first_pos;
                state_d = WSS_RUN;
            end
        end
    end

    // State, offset counter, held word and highest-offset registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= WSS_IDLE;
            word_q  <= '0;
            pos_q   <= '0;
            maxp_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            pos_q   <= pos_d;
            maxp_q  <= maxp_d;
        end
    end

    word_shift #(
        .CHAR_BITS    (CHAR_BITS),
        .WORD_MAX_LEN (WORD_MAX_LEN)
    ) u_shift (
        .word_i (word_q),
        .pos_i  (pos_q),
        .word_o (shifted)
    );

    // Output copy is a pure function of the held word and current offset.
    always_comb begin
        out_valid = run;
        out_last  = run & at_final;
        out_pos   = pos_q;
        out_word  = shifted;
    end

endmodule

// File: tb/tb_word_shift_seq.sv
// Self-checking bench for word_shift_seq (default 7-bit chars, 8-char field).
// A queue model predicts every copy; directed literals pin the model.

module tb_word_shift_seq;

`ifdef WORD_SHIFT_SEQ_REVERSE_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    localparam int CB = 7;
    localparam int ML = 8;

    logic        CLK;
    logic        RST;
    logic [55:0] in_word;
    logic [3:0]  in_len;
    logic        in_valid;
    logic        in_ready;
    logic [55:0] out_word;
    logic [2:0]  out_pos;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    word_shift_seq dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_word   (in_word),
        .in_len    (in_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_word  (out_word),
        .out_pos   (out_pos),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [55:0] w;
        int          p;
        bit          l;
    } exp_t;

    exp_t exp_q[$];
    int   obs_pos[$];
    int   obs_last[$];
    int   obs_cyc[$];
    logic [55:0] obs_word[$];
    int   hs_cyc[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit started = 0;
    int rdy_mode = 0;
    int rdy_ph   = 0;

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Model: every offset 0..8-min(len,8), shifted by whole characters.
    function automatic void model_push(input logic [55:0] w, input int len);
        int eff;
        int mp;
        exp_t e;
        eff = (len > ML) ? ML : len;
        if (eff == 0) return;
        mp = ML - eff;
        for (int k = 0; k <= mp; k++) begin
            e.p = REV ? (mp - k) : k;
            e.w = w >> (e.p * CB);
            e.l = (k == mp);
            exp_q.push_back(e);
        end
    endfunction

    // Per-cycle compare against the model; logs accepted copies.
    always @(negedge CLK) begin
        int   n;
        exp_t e;
        if (started) begin
            if (RST) begin
                exp_q.delete();
            end else begin
                n = exp_q.size();
                check("out_valid", 64'(out_valid), 64'(n > 0));
                check("in_ready", 64'(in_ready),
                      64'((n == 0) || (n == 1 && out_ready)));
                if (n > 0) begin
                    e = exp_q[0];
                    check("out_word", 64'(out_word), 64'(e.w));
                    check("out_pos", 64'(out_pos), 64'(e.p));
                    check("out_last", 64'(out_last), 64'(e.l));
                    if (out_ready) void'(exp_q.pop_front());
                end
                if (out_valid && out_ready) begin
                    obs_pos.push_back(int'(out_pos));
                    obs_last.push_back(int'(out_last));
                    obs_word.push_back(out_word);
                    obs_cyc.push_back(cyc);
                end
                if (in_valid && in_ready) begin
                    hs_cyc.push_back(cyc);
                    model_push(in_word, int'(in_len));
                end
            end
        end
    end

    // out_ready driver: held high, or the 1,0,0 stall pattern.
    initial begin
        out_ready = 1;
        forever begin
            @(posedge CLK);
            #1;
            if (rdy_mode == 0) begin
                out_ready = 1;
            end else begin
                out_ready = (rdy_ph == 0);
                rdy_ph = (rdy_ph + 1) % 3;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_logs();
        obs_pos.delete();
        obs_last.delete();
        obs_word.delete();
        obs_cyc.delete();
        hs_cyc.delete();
    endtask

    // Present a word and hold it until accepted; in_valid stays high.
    task automatic send_word(input logic [55:0] w, input int len);
        bit ok;
        ok = 0;
        in_word  = w;
        in_len   = 4'(len);
        in_valid = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        check("send_timeout", 64'(ok), 64'(1));
        step();
    endtask

    task automatic idle_in();
        in_valid = 0;
        in_word  = '0;
        in_len   = '0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (!out_valid) begin
                ok = 1;
                break;
            end
        end
        check("drain_timeout", 64'(ok), 64'(1));
        step();
    endtask

    logic [55:0] w_ab, w_6, w_8, w_7, w_15, w_1, w_2, w_5, exp3;

    initial begin
        w_ab = {7'h41, 7'h42, 42'h0};
        w_6  = {7'h31, 7'h32, 7'h33, 7'h34, 7'h35, 7'h36, 14'h0};
        w_8  = {7'h61, 7'h62, 7'h63, 7'h64, 7'h65, 7'h66, 7'h67, 7'h68};
        w_7  = {7'h71, 7'h72, 7'h73, 7'h74, 7'h75, 7'h76, 7'h77, 7'h0};
        w_15 = {7'h51, 7'h52, 7'h53, 7'h54, 7'h55, 7'h56, 7'h57, 7'h58};
        w_1  = {7'h5a, 49'h0};
        w_2  = {7'h43, 7'h44, 42'h0};
        w_5  = {7'h11, 7'h22, 7'h33, 7'h44, 7'h55, 21'h0};
        exp3 = {21'h0, 7'h41, 7'h42, 21'h0};

        RST = 1;
        idle_in();
        repeat (3) @(posedge CLK);
        #1;
        RST = 0;
        @(negedge CLK);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_out_pos", 64'(out_pos), 64'(0));
        check("rst_out_word", 64'(out_word), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        started = 1;
        step();

        // Basic: "AB", len 2 -> 7 copies, one per cycle.
        clear_logs();
        send_word(w_ab, 2);
        idle_in();
        drain();
        check("basic_count", 64'(obs_pos.size()), 64'(7));
        if (obs_pos.size() == 7) begin
            for (int i = 0; i < 7; i++) begin
                check("basic_pos", 64'(obs_pos[i]), 64'(REV ? 6 - i : i));
                check("basic_last", 64'(obs_last[i]), 64'(i == 6));
            end
            check("basic_copy3", 64'(obs_word[3]), 64'(exp3));
            check("basic_latency", 64'(obs_cyc[0]), 64'(hs_cyc[0] + 1));
            check("basic_rate", 64'(obs_cyc[6]), 64'(obs_cyc[0] + 6));
        end

        // Backpressure: len 6 with out_ready pattern 1,0,0.
        clear_logs();
        rdy_ph = 0;
        rdy_mode = 1;
        send_word(w_6, 6);
        idle_in();
        drain();
        rdy_mode = 0;
        step();
        check("bp_count", 64'(obs_pos.size()), 64'(3));
        if (obs_pos.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("bp_pos", 64'(obs_pos[i]), 64'(REV ? 2 - i : i));
            end
            check("bp_last", 64'(obs_last[2]), 64'(1));
        end

        // Back-to-back: len 8 then len 7 with in_valid continuous.
        clear_logs();
        send_word(w_8, 8);
        send_word(w_7, 7);
        idle_in();
        drain();
        check("b2b_count", 64'(obs_pos.size()), 64'(3));
        if (obs_pos.size() == 3) begin
            check("b2b_pos0", 64'(obs_pos[0]), 64'(0));
            check("b2b_last0", 64'(obs_last[0]), 64'(1));
            check("b2b_pos1", 64'(obs_pos[1]), 64'(REV ? 1 : 0));
            check("b2b_last1", 64'(obs_last[1]), 64'(0));
            check("b2b_pos2", 64'(obs_pos[2]), 64'(REV ? 0 : 1));
            check("b2b_last2", 64'(obs_last[2]), 64'(1));
            check("b2b_word0", 64'(obs_word[0]), 64'(w_8));
            check("b2b_nobubble", 64'(obs_cyc[2]), 64'(obs_cyc[0] + 2));
        end

        // Edge lengths: len 0 (consumed silently), then len 15 (clamped).
        clear_logs();
        send_word(w_5, 0);
        send_word(w_15, 15);
        idle_in();
        drain();
        check("edge_accepts", 64'(hs_cyc.size()), 64'(2));
        check("edge_count", 64'(obs_pos.size()), 64'(1));
        if (obs_pos.size() == 1) begin
            check("edge_pos", 64'(obs_pos[0]), 64'(0));
            check("edge_last", 64'(obs_last[0]), 64'(1));
            check("edge_word", 64'(obs_word[0]), 64'(w_15));
        end

        // Reset mid-word: len 1, reset after offset 3 is consumed.
        clear_logs();
        send_word(w_1, 1);
        idle_in();
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            if (obs_pos.size() >= 4) break;
        end
        #1;
        RST = 1;
        step();
        RST = 0;
        @(negedge CLK);
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_ready", 64'(in_ready), 64'(1));
        check("mid_rst_word", 64'(out_word), 64'(0));
        check("mid_rst_seen", 64'(obs_pos.size()), 64'(4));
        check("mid_rst_pos3", 64'(obs_pos[3]), 64'(REV ? 4 : 3));
        step();
        send_word(w_2, 2);
        idle_in();
        drain();
        check("restart_count", 64'(obs_pos.size()), 64'(11));
        if (obs_pos.size() == 11) begin
            check("restart_pos", 64'(obs_pos[4]), 64'(REV ? 6 : 0));
        end

        // Len 5: offsets 0..3 (or 3..0 in reverse), last on the final one.
        clear_logs();
        send_word(w_5, 5);
        idle_in();
        drain();
        check("len5_count", 64'(obs_pos.size()), 64'(4));
        if (obs_pos.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("len5_pos", 64'(obs_pos[i]), 64'(REV ? 3 - i : i));
                check("len5_last", 64'(obs_last[i]), 64'(i == 3));
            end
            check("len5_word", 64'(obs_word[REV ? 0 : 3]),
                  64'({21'h0, 7'h11, 7'h22, 7'h33, 7'h44, 7'h55}));
        end

        repeat (3) step();
        check("tail_model_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
